jacobi_sweep_sched: RTL

Sequencer for the Jacobi eigen-decomposition of the N_STOCKS x N_STOCKS covariance matrix.
- Walks the cyclic-by-row pivot order (p,q), p<q, and issues one rotation request per pair to the rotation datapath. It does not start the next pair until that rotation completes.
- At every sweep boundary, and before the first sweep, it samples the combinational off-diagonal convergence flag.
- Stops on convergence, on MAX_SWEEPS, or on abort, and reports the result to the top-level trading FSM.

---
 rtl/jacobi_sweep_sched_if.sv | 33 +++
 rtl/jacobi_sweep_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/jacobi_sweep_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : jacobi_sweep_sched_if
// Brief    : Rotation request channel between the Jacobi sweep sequencer and
//            the rotation datapath (valid/ready request, done completion).
// Revision : 1.0
// ============================================================================
interface jacobi_sweep_sched_if #(
    parameter int IDX_W = 2
) ();
    logic             rot_valid_out;
    logic             rot_ready_in;
    logic [IDX_W-1:0] rot_p_out;
    logic [IDX_W-1:0] rot_q_out;
    logic             rot_done_in;

    modport master (
        output rot_valid_out,
        output rot_p_out,
        output rot_q_out,
        input  rot_ready_in,
        input  rot_done_in
    );

    modport slave (
        input  rot_valid_out,
        input  rot_p_out,
        input  rot_q_out,
        output rot_ready_in,
        output rot_done_in
    );
endinterface
`default_nettype wire

// File: rtl/jacobi_sweep_sched.sv
`default_nettype none
// ============================================================================
// Module   : jacobi_sweep_sched
// Brief    : Cyclic-by-row pivot sequencer for the Jacobi eigen-decomposition;
//            one rotation in flight at a time, convergence tested per sweep.
// Revision : 1.0
// ============================================================================
module jacobi_sweep_sched #(
    parameter int N_STOCKS   = 4,
    parameter int MAX_SWEEPS = 8,
    parameter int IDX_W      = $clog2(N_STOCKS),
    parameter int SW_W       = $clog2(MAX_SWEEPS + 1)
) (
    input  wire logic                 clk_in,
    input  wire logic                 rst_in,
    input  wire logic                 start_in,
    input  wire logic                 abort_in,
    input  wire logic                 conv_in,
    jacobi_sweep_sched_if.master      rot,
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      converged_out,
    output logic [SW_W-1:0]           sweeps_out
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_STOCKS - 1);
    localparam logic [IDX_W-1:0] c_PEN_IDX  = IDX_W'(N_STOCKS - 2);
    localparam logic [SW_W-1:0]  c_MAX_SW   = SW_W'(MAX_SWEEPS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_p;
    logic [IDX_W-1:0]  r_q;
    logic [SW_W-1:0]   r_sweeps;
    logic              r_abort;
    logic              r_rot_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_conv;

    logic w_fire;
    logic w_abort;
    logic w_sweep_end;

    assign w_fire      = r_rot_valid && rot.rot_ready_in;
    assign w_abort     = r_abort || abort_in;
    // The last pair of a sweep is (N-2, N-1).
    assign w_sweep_end = (r_p == c_PEN_IDX) && (r_q == c_LAST_IDX);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_p         <= '0;
            r_q         <= IDX_W'(1);
            r_sweeps    <= '0;
            r_abort     <= 1'b0;
            r_rot_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_conv      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && abort_in) begin
                r_abort <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_state  <= S_CHECK;
                        r_busy   <= 1'b1;
                        r_sweeps <= '0;
                        r_conv   <= 1'b0;
                        r_p      <= '0;
                        r_q      <= IDX_W'(1);
                        r_abort  <= 1'b0;
                    end
                end

                S_CHECK: begin
                    if (conv_in) begin
                        r_conv  <= 1'b1;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (w_abort || r_sweeps == c_MAX_SW) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= S_ISSUE;
                        r_rot_valid <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    // A handshake on the same edge as abort still goes through;
                    // the abort is then honoured once that rotation completes.
                    if (w_fire) begin
                        r_rot_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end else if (abort_in) begin
                        r_rot_valid <= 1'b0;
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (rot.rot_done_in) begin
                        if (w_sweep_end) begin
                            r_sweeps <= r_sweeps + SW_W'(1);
                            r_p      <= '0;
                            r_q      <= IDX_W'(1);
                            r_state  <= S_CHECK;
                        end else begin
                            if (r_q < c_LAST_IDX) begin
                                r_q <= r_q + IDX_W'(1);
                            end else begin
                                r_p <= r_p + IDX_W'(1);
                                r_q <= r_p + IDX_W'(2);
                            end
                            if (w_abort) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= S_ISSUE;
                                r_rot_valid <= 1'b1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_rot_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign rot.rot_valid_out = r_rot_valid;
    assign rot.rot_p_out     = r_p;
    assign rot.rot_q_out     = r_q;
    assign busy_out          = r_busy;
    assign done_out          = r_done;
    assign converged_out     = r_conv;
    assign sweeps_out        = r_sweeps;

endmodule
`default_nettype wire
